imem_program_loader: RTL
========================

IMEM_PROGRAM_LOADER -- requirements
Module: imem_program_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'd0: the instruction-memory word address of the first loaded instruction.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a program load.
REQ-005 The block SHALL have port in_byte, input, 8 bits: program byte stream data.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_byte holds a valid byte.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 The block SHALL have port imem_wr_en, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port imem_wr_addr, output, 32 bits: instruction-memory word address.
REQ-010 The block SHALL have port imem_wr_data, output, 32 bits: instruction word to write.
REQ-011 The block SHALL have port cpu_reset, output, 1 bit: holds the program counter in reset while high.
REQ-012 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: the last load completed.
REQ-014 The block SHALL have port word_count, output, 8 bits: number of words written in the current or last load.

Function
REQ-015 The block SHALL accept a byte only on a rising edge where in_valid=1 and in_ready=1; in_byte is ignored when in_ready=0.
REQ-016 The block SHALL implement states IDLE, LEN, COLLECT, WRITE and DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE, start=1 SHALL move the block to LEN and clear word_count, done and the byte index; start SHALL be ignored in all other states.
REQ-018 In LEN, in_ready SHALL be 1; the first accepted byte is the word count N.
REQ-019 If N=0, the block SHALL go directly to DONE with no write.
REQ-020 If N>0, the block SHALL store N and go to COLLECT.
REQ-021 In COLLECT, in_ready SHALL be 1; accepted byte i (0..3) SHALL be placed at bits 8i+7:8i of the word, so the first byte is the LSB (little-endian).
REQ-022 On acceptance of the 4th byte, the block SHALL go to WRITE; in_ready SHALL be 0 during WRITE.
REQ-023 WRITE SHALL last exactly one cycle and drive imem_wr_en=1, imem_wr_addr=BASE_ADDR+word_count (modulo 2^32) and imem_wr_data=the assembled word.
REQ-024 word_count SHALL increment at the end of WRITE; the next state SHALL be DONE if the new count equals N, otherwise COLLECT.
REQ-025 imem_wr_en SHALL be 0 in every state other than WRITE; imem_wr_addr and imem_wr_data SHALL hold their last values outside WRITE.
REQ-026 Latency: imem_wr_en SHALL assert in the cycle immediately after the edge that accepted the 4th byte; minimum throughput is 5 cycles per word.
REQ-027 busy SHALL be 1 in LEN, COLLECT and WRITE, and 0 otherwise.
REQ-028 cpu_reset SHALL be 1 in every state except DONE; in DONE, cpu_reset=0, done=1 and in_ready=0.
REQ-029 A restart from DONE SHALL reassert cpu_reset=1 in the first LEN cycle.
REQ-030 Gaps in in_valid SHALL stall the block with no state change, no write and no data loss.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL enter IDLE and set in_ready=0, imem_wr_en=0, imem_wr_addr=BASE_ADDR, imem_wr_data=0, cpu_reset=1, busy=0, done=0, word_count=0, byte index=0 and N=0.
REQ-032 Reset SHALL take priority over start and over byte acceptance in the same cycle.
REQ-033 A reset during a load SHALL discard any partial word with no write.

Verification
REQ-034 Reset check: reset held 2 cycles -> cpu_reset=1, in_ready=0, done=0, busy=0, imem_wr_en=0.
REQ-035 Basic load: BASE_ADDR=0, start, bytes 02,01,02,03,04,05,06,07,08 -> writes (addr 0, data 0x04030201) and (addr 1, data 0x08070605), each with a single-cycle imem_wr_en; then done=1, cpu_reset=0, word_count=2.
REQ-036 Empty load: start, byte 00 -> DONE on the next edge, no imem_wr_en pulse, word_count=0.
REQ-037 Stalls: as the basic-load case but with in_valid low for 3 cycles between every byte -> identical writes, and bytes offered during WRITE are not consumed.
REQ-038 Abort: reset asserted after 2 data bytes of word 0 -> no write and all outputs at reset values; a subsequent load of 01,AA,BB,CC,DD -> writes 0xDDCCBBAA to BASE_ADDR.
REQ-039 Start ignored and restart: start pulsed during COLLECT -> no effect; start in DONE -> cpu_reset=1, done=0, word_count=0; with BASE_ADDR=32'hFFFFFFFF and N=2, the second write goes to address 0.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master drives the byte stream and observes writes; the slave is the loader.
interface imem_program_loader_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;

  modport master (
    output in_byte, in_valid,
    input  in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the CPU in reset until the whole program has been written.
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  imem_program_loader_if.slave         bus,
  output logic                         cpu_reset,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_COLLECT, S_WRITE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  wc_q, wc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        in_ready_q, in_ready_d;
  logic        wr_en_q, wr_en_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;
  logic [7:0]  wc_inc;

  assign accept = in_ready_q & bus.in_valid;
  assign wc_inc = wc_q + 8'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          wc_d    = 8'd0;
          idx_d   = 2'd0;
        end
      end
      S_LEN: begin
        if (accept) begin
          n_d     = bus.in_byte;
          state_d = (bus.in_byte == 8'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            // Fourth byte goes straight into the write register, not the buffer.
            state_d = S_WRITE;
            idx_d   = 2'd0;
            addr_d  = BASE_ADDR + {24'd0, wc_q};
            data_d  = {bus.in_byte, word_q};
          end else begin
            word_d[{idx_q, 3'b000} +: 8] = bus.in_byte;
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        wc_d    = wc_inc;
        state_d = (wc_inc == n_q) ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    in_ready_d  = (state_d == S_LEN) || (state_d == S_COLLECT);
    wr_en_d     = (state_d == S_WRITE);
    busy_d      = (state_d == S_LEN) || (state_d == S_COLLECT) || (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= 8'd0;
      idx_q       <= 2'd0;
      word_q      <= 24'd0;
      wc_q        <= 8'd0;
      addr_q      <= BASE_ADDR;
      data_q      <= 32'd0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      wc_q        <= wc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_wr_addr = addr_q;
  assign bus.imem_wr_data = data_q;
  assign cpu_reset        = cpu_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign word_count       = wc_q;

endmodule
